// File: rtl/ppu_mem_responder.sv
// ppu_mem_responder
//   Byte-wide memory responder for the PPU. It holds the control registers
//   (FLAGS, FRONT/BACK/PALLET/SPRITES pointers, WINDOW, CLEAR_COLOR) and the
//   sprite/pallet RAM. Initiators reach it through the shared io_mem_data
//   bus, and the host writes through a separate write port.
//
// Handshake: the initiator raises i_mem_read or i_mem_write and holds it,
//   together with i_mem_address (and the write data on io_mem_data), until
//   o_mem_valid is seen. A request is accepted only in IDLE.
//   o_mem_valid is a one-cycle strobe in RESP. The responder drives
//   io_mem_data only in RESP of a read while i_mem_read is still high.
//   If the request is still held after RESP, it counts as a new access.
//
// Ports:
//   i_clock, i_reset_n           clock, synchronous active-low reset
//   i_mem_read, i_mem_write      initiator requests
//   i_mem_address [31:0]         initiator byte address
//   io_mem_data [7:0]            shared data bus (write data in, read data out)
//   o_mem_valid, o_mem_error     completion strobe / fault flag
//   i_host_write, i_host_address [31:0], i_host_data [7:0]   host write port
//   o_start_draw                 one-cycle draw start pulse
//   o_debug_state [1:0]          current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module ppu_mem_responder #(
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] RAM_BASE     = 32'h0000_1000,
    parameter int unsigned RAM_BYTES    = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_mem_address,
    inout  wire  [7:0]  io_mem_data,
    output logic        o_mem_valid,
    output logic        o_mem_error,
    input  logic        i_host_write,
    input  logic [31:0] i_host_address,
    input  logic [7:0]  i_host_data,
    output logic        o_start_draw,
    output logic [1:0]  o_debug_state
);
    localparam int AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
    localparam int IW = (AW > 4) ? AW : 4;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
    typedef enum logic [2:0] {RG_NONE, RG_FLAGS, RG_PTRS, RG_VIEW, RG_RAM} region_t;
    typedef struct packed {
        region_t         region;
        logic [IW-1:0]   index;
    } decode_t;

    // Address decode shared by the memory side and the host side.
    function automatic decode_t decode(input logic [31:0] addr);
        decode_t     d;
        logic [32:0] off;
        d.region = RG_NONE;
        d.index  = '0;
        off      = {1'b0, addr} - {1'b0, RAM_BASE};
        if (addr <= 32'h3) begin
            d.region = RG_FLAGS;
            d.index  = IW'(addr[3:0]);
        end else if (addr >= 32'h100 && addr <= 32'h10F) begin
            d.region = RG_PTRS;
            d.index  = IW'(addr[3:0]);
        end else if (addr >= 32'h200 && addr <= 32'h20E) begin
            d.region = RG_VIEW;
            d.index  = IW'(addr[3:0]);
        end else if (addr >= RAM_BASE && off < 33'(RAM_BYTES)) begin
            d.region = RG_RAM;
            d.index  = IW'(off[AW-1:0]);
        end
        return d;
    endfunction

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [7:0]  rdata_q;
    logic        resp_read;

    logic [7:0]  flags_q [4];
    logic [7:0]  ptrs_q  [16];
    logic [7:0]  view_q  [15];   // WINDOW 0x200-0x20B, CLEAR_COLOR 0x20C-0x20E
    logic [7:0]  ram_q   [RAM_BYTES];

    decode_t     mem_dec;
    decode_t     host_dec;
    decode_t     rd_dec;
    logic [7:0]  rd_now;
    logic        wr_clash;
    logic        mem_we;
    logic        drive_en;

    assign mem_dec  = decode(i_mem_address);
    assign host_dec = decode(i_host_address);

    // In IDLE (READ_LATENCY == 1) the live address is sampled, otherwise the captured one.
    assign rd_dec = decode((state == ST_IDLE) ? i_mem_address : addr_q);

    always_comb begin
        rd_now = 8'h00;
        case (rd_dec.region)
            RG_FLAGS: rd_now = flags_q[rd_dec.index[1:0]];
            RG_PTRS:  rd_now = ptrs_q[rd_dec.index[3:0]];
            RG_VIEW:  rd_now = view_q[rd_dec.index[3:0]];
            RG_RAM:   rd_now = ram_q[rd_dec.index[AW-1:0]];
            default:  rd_now = 8'h00;
        endcase
    end

    // A memory-side write loses to a host write of the same byte on the same edge.
    assign wr_clash = i_host_write && (host_dec.region != RG_NONE) &&
                      (i_host_address == i_mem_address);
    assign mem_we   = i_reset_n && (state == ST_IDLE) && i_mem_write && !i_mem_read &&
                      (mem_dec.region != RG_NONE) && !wr_clash;

    // Control registers. FLAGS byte 3 bit0 is a trigger and never stores a 1.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 4; i++)  flags_q[i] <= 8'h00;
            for (int i = 0; i < 16; i++) ptrs_q[i]  <= 8'h00;
            for (int i = 0; i < 15; i++) view_q[i]  <= 8'h00;
        end else begin
            if (mem_we) begin
                case (mem_dec.region)
                    RG_FLAGS: flags_q[mem_dec.index[1:0]] <= (mem_dec.index[1:0] == 2'd3) ?
                                                            (io_mem_data & 8'hFE) : io_mem_data;
                    RG_PTRS:  ptrs_q[mem_dec.index[3:0]] <= io_mem_data;
                    RG_VIEW:  view_q[mem_dec.index[3:0]] <= io_mem_data;
                    default:  ;
                endcase
            end
            if (i_host_write) begin
                case (host_dec.region)
                    RG_FLAGS: flags_q[host_dec.index[1:0]] <= (host_dec.index[1:0] == 2'd3) ?
                                                             (i_host_data & 8'hFE) : i_host_data;
                    RG_PTRS:  ptrs_q[host_dec.index[3:0]] <= i_host_data;
                    RG_VIEW:  view_q[host_dec.index[3:0]] <= i_host_data;
                    default:  ;
                endcase
            end
        end
    end

    // RAM keeps its contents through reset but takes no writes while reset is low.
    always_ff @(posedge i_clock) begin
        if (i_reset_n) begin
            if (mem_we && mem_dec.region == RG_RAM)
                ram_q[mem_dec.index[AW-1:0]] <= io_mem_data;
            if (i_host_write && host_dec.region == RG_RAM)
                ram_q[host_dec.index[AW-1:0]] <= i_host_data;
        end
    end

    // Access FSM with registered strobes.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            addr_q       <= 32'h0;
            rdata_q      <= 8'h00;
            resp_read    <= 1'b0;
            o_mem_valid  <= 1'b0;
            o_mem_error  <= 1'b0;
            o_start_draw <= 1'b0;
        end else begin
            o_mem_valid  <= 1'b0;
            o_mem_error  <= 1'b0;
            o_start_draw <= i_host_write && (i_host_address == 32'h3) && i_host_data[0];
            case (state)
                ST_IDLE: begin
                    if (i_mem_read && i_mem_write) begin
                        state       <= ST_RESP;
                        resp_read   <= 1'b0;
                        o_mem_valid <= 1'b1;
                        o_mem_error <= 1'b1;
                    end else if (i_mem_write) begin
                        state       <= ST_RESP;
                        resp_read   <= 1'b0;
                        o_mem_valid <= 1'b1;
                        o_mem_error <= (mem_dec.region == RG_NONE) || wr_clash;
                    end else if (i_mem_read) begin
                        addr_q    <= i_mem_address;
                        resp_read <= 1'b1;
                        if (READ_LATENCY <= 1) begin
                            state       <= ST_RESP;
                            rdata_q     <= rd_now;
                            o_mem_valid <= 1'b1;
                            o_mem_error <= (rd_dec.region == RG_NONE);
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(READ_LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_mem_read) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 4'd1) begin
                        state       <= ST_RESP;
                        rdata_q     <= rd_now;
                        o_mem_valid <= 1'b1;
                        o_mem_error <= (rd_dec.region == RG_NONE);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    resp_read <= 1'b0;
                end
            endcase
        end
    end

    assign drive_en      = (state == ST_RESP) && resp_read && i_mem_read;
    assign io_mem_data   = drive_en ? rdata_q : 8'hzz;
    assign o_debug_state = state;

endmodule

// File: tb/tb_ppu_mem_responder.sv
module tb_ppu_mem_responder;
    localparam int unsigned LAT      = 2;
    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam int unsigned RAM_SZ   = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        tb_oe;
    logic [7:0]  tb_drive;
    logic        mem_valid, mem_error;
    logic        host_write;
    logic [31:0] host_addr;
    logic [7:0]  host_data;
    logic        start_draw;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];   // {error, data}

    assign mem_data = tb_oe ? tb_drive : 8'hzz;

    ppu_mem_responder #(.READ_LATENCY(LAT), .RAM_BASE(RAM_BASE), .RAM_BYTES(RAM_SZ)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_address(mem_addr),
        .io_mem_data(mem_data), .o_mem_valid(mem_valid), .o_mem_error(mem_error),
        .i_host_write(host_write), .i_host_address(host_addr), .i_host_data(host_data),
        .o_start_draw(start_draw), .o_debug_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for o_mem_valid, sampled at negedges; returns negedges counted.
    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!mem_valid && cycles < 20);
        check({tag, "_valid_seen"}, 32'(mem_valid), 32'd1);
    endtask

    task automatic host_wr(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        host_write = 1'b1; host_addr = a; host_data = d;
        @(negedge clk);
        host_write = 1'b0;
    endtask

    task automatic mem_rd(input string tag, input logic [31:0] a,
                          input logic [7:0] exp_d, input logic exp_e);
        int cyc;
        logic [8:0] e;
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        mem_read = 1'b1; mem_addr = a;
        wait_valid(tag, cyc);
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_data"}, 32'(mem_data), 32'(e[7:0]));
        check({tag, "_error"}, 32'(mem_error), 32'(e[8]));
        mem_read = 1'b0;
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(mem_valid), 32'd0);
    endtask

    task automatic mem_wr(input string tag, input logic [31:0] a, input logic [7:0] d,
                          input logic exp_e, input logic with_host, input logic [7:0] hd);
        int cyc;
        logic [8:0] e;
        exp_q.push_back({exp_e, 8'h00});
        @(negedge clk);
        mem_write = 1'b1; mem_addr = a; tb_oe = 1'b1; tb_drive = d;
        if (with_host) begin
            host_write = 1'b1; host_addr = a; host_data = hd;
        end
        wait_valid(tag, cyc);
        host_write = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(cyc), 32'd1);
        check({tag, "_error"}, 32'(mem_error), 32'(e[8]));
        mem_write = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        logic [31:0] ra [4];
        logic [7:0]  rd [4];
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
        tb_oe = 1'b0; tb_drive = '0; host_write = 1'b0; host_addr = '0; host_data = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_error", 32'(mem_error), 32'd0);
        check("rst_start", 32'(start_draw), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_bus_z", 32'(dut.drive_en), 32'd0);
        rst_n = 1'b1;

        // WINDOW via host, read back through the memory side
        for (int i = 0; i < 12; i++) host_wr(32'h200 + 32'(i), 8'(i + 1));
        for (int i = 0; i < 12; i++) mem_rd($sformatf("window%0d", i), 32'h200 + 32'(i), 8'(i + 1), 1'b0);

        // RAM write/read, range edges
        mem_wr("ram_wr5", RAM_BASE + 5, 8'hA5, 1'b0, 1'b0, 8'h00);
        mem_rd("ram_rd5", RAM_BASE + 5, 8'hA5, 1'b0);
        mem_wr("ram_wr_last", RAM_BASE + RAM_SZ - 1, 8'h3C, 1'b0, 1'b0, 8'h00);
        mem_rd("ram_rd_last", RAM_BASE + RAM_SZ - 1, 8'h3C, 1'b0);
        mem_rd("ram_rd_past", RAM_BASE + RAM_SZ, 8'h00, 1'b1);
        mem_rd("ram_rd_below", RAM_BASE - 1, 8'h00, 1'b1);
        mem_wr("unmapped_wr", 32'h300, 8'h55, 1'b1, 1'b0, 8'h00);
        mem_rd("unmapped_rd", 32'h300, 8'h00, 1'b1);
        mem_rd("clear_unused", 32'h20F, 8'h00, 1'b1);

        // random RAM bytes via host, read on the memory side
        for (int i = 0; i < 4; i++) begin
            ra[i] = RAM_BASE + 32'(16 + 64 * i + $urandom_range(0, 63));
            rd[i] = 8'($urandom_range(0, 255));
            host_wr(ra[i], rd[i]);
        end
        for (int i = 0; i < 4; i++) mem_rd($sformatf("ram_rand%0d", i), ra[i], rd[i], 1'b0);

        // draw start from host; bit0 self-clears
        host_wr(32'h3, 8'h03);
        check("start_pulse", 32'(start_draw), 32'd1);
        @(negedge clk);
        check("start_pulse_end", 32'(start_draw), 32'd0);
        mem_rd("flags3", 32'h3, 8'h02, 1'b0);
        // memory-side write to FLAGS never starts a draw
        seen = 0;
        fork
            mem_wr("flags_memwr", 32'h3, 8'h01, 1'b0, 1'b0, 8'h00);
            repeat (5) @(negedge clk) if (start_draw) seen++;
        join
        check("no_start_memwr", 32'(seen), 32'd0);

        // read and write together
        host_wr(32'h100, 8'h77);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h100;
        tb_oe = 1'b1; tb_drive = 8'h99;
        wait_valid("rdwr", seen);
        check("rdwr_error", 32'(mem_error), 32'd1);
        check("rdwr_bus_z", 32'(dut.drive_en), 32'd0);
        mem_read = 1'b0; mem_write = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
        mem_rd("front_kept", 32'h100, 8'h77, 1'b0);

        // read dropped in WAIT
        @(negedge clk);
        mem_read = 1'b1; mem_addr = 32'h104;
        @(negedge clk);
        check("abort_in_wait", 32'(dbg_state), 32'd1);
        mem_read = 1'b0;
        seen = 0;
        repeat (4) @(negedge clk) if (mem_valid) seen++;
        check("abort_no_valid", 32'(seen), 32'd0);

        // reset during WAIT
        mem_read = 1'b1; mem_addr = 32'h108;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(mem_valid), 32'd0);
        check("midrst_error", 32'(mem_error), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_bus_z", 32'(dut.drive_en), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        check("midrst_valid2", 32'(mem_valid), 32'd0);
        rst_n = 1'b1;
        mem_rd("regs_cleared", 32'h200, 8'h00, 1'b0);
        mem_rd("ram_survives", RAM_BASE + 5, 8'hA5, 1'b0);

        // host and memory write to the same byte on the same edge
        mem_wr("clash_wr", 32'h20C, 8'h22, 1'b1, 1'b1, 8'h11);
        mem_rd("clash_rd", 32'h20C, 8'h11, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ppu_mem_responder.md
PPU_MEM_RESPONDER -- requirements
Module: ppu_mem_responder

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, cycles from read acceptance to o_mem_valid; legal range 1..15.
REQ-002 SHALL have parameter RAM_BASE, default 32'h0000_1000, byte address of sprite/pallet RAM region.
REQ-003 SHALL have parameter RAM_BYTES, default 1024, size of RAM region in bytes (power of two).
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-006 i_reset_n  input  1  synchronous active-low reset.
REQ-007 i_mem_read  input  1  initiator read request, held until o_mem_valid.
REQ-008 i_mem_write  input  1  initiator write request, held until o_mem_valid.
REQ-009 i_mem_address  input  32  byte address of request.
REQ-010 io_mem_data  inout  8  shared byte bus; responder drives only per REQ-020.
REQ-011 o_mem_valid  output  1  one-cycle completion strobe.
REQ-012 o_mem_error  output  1  one-cycle strobe, coincident with o_mem_valid, for faulted access.
REQ-013 i_host_write  input  1  host-side register/RAM write strobe.
REQ-014 i_host_address  input  32  host write byte address.
REQ-015 i_host_data  input  8  host write data.
REQ-016 o_start_draw  output  1  one-cycle pulse to PPU draw start.

Function
REQ-017 Register map, big-endian (MSB at lowest address): FLAGS 0x000-0x003, FRONT 0x100-0x103, BACK 0x104-0x107, PALLET 0x108-0x10B, SPRITES 0x10C-0x10F, WINDOW 0x200-0x20B (x, y, m_00, m_01, m_10, m_11, 16 bits each), CLEAR_COLOR 0x20C-0x20E (R,G,B); RAM at RAM_BASE..RAM_BASE+RAM_BYTES-1; all other addresses unmapped.
REQ-018 States IDLE, WAIT, RESP; request accepted only in IDLE; address (and write data from io_mem_data) captured on acceptance edge.
REQ-019 Read: IDLE -> WAIT for READ_LATENCY-1 cycles -> RESP; READ_LATENCY=1 goes IDLE -> RESP directly; read data sampled from storage on the edge entering RESP.
REQ-020 io_mem_data driven with read data only while state is RESP of a read and i_mem_read is high; Z otherwise.
REQ-021 Write: storage updated on acceptance edge; IDLE -> RESP; o_mem_valid high for the RESP cycle.
REQ-022 o_mem_valid high exactly one cycle (RESP), then IDLE; a still-asserted request is re-accepted next cycle as a new access (back-to-back throughput 1 access per READ_LATENCY+1 cycles for reads, 2 for writes).
REQ-023 i_mem_read and i_mem_write both high in IDLE: no storage change, RESP with o_mem_valid=1, o_mem_error=1, bus not driven.
REQ-024 Unmapped read: returns 8'h00 with o_mem_error=1; unmapped write: dropped, o_mem_error=1.
REQ-025 i_mem_read deasserted during WAIT: access aborted, return to IDLE, no o_mem_valid.
REQ-026 Host write applies on the edge i_host_write is high, in any state; mapped same as REQ-017, unmapped host writes ignored.
REQ-027 Host write and memory-side write to same byte on same edge: host data wins; memory-side access still completes with o_mem_error=1.
REQ-028 Host write to 0x003 with bit0=1: o_start_draw pulses high the following cycle; FLAGS bit0 self-clears (reads back 0); other FLAGS bits store normally.
REQ-029 Memory-side writes to FLAGS never trigger o_start_draw.
REQ-030 RAM address index = address - RAM_BASE, low log2(RAM_BYTES) bits; no wrap beyond region (out-of-range is unmapped).

Reset
REQ-031 i_reset_n low at a rising edge: state IDLE, o_mem_valid=0, o_mem_error=0, o_start_draw=0, io_mem_data Z, all control registers 8'h00; RAM contents unchanged.
REQ-032 Reset mid-access: access abandoned, no o_mem_valid, no storage update after that edge.

Verification
REQ-033 Host writes 0x200..0x20B = 01..0C; memory-side reads 0x200..0x20B, READ_LATENCY=2 -> each returns 01..0C, o_mem_valid 2 cycles after acceptance, o_mem_error=0.
REQ-034 Memory-side write 8'hA5 to RAM_BASE+5, then read -> 8'hA5; read RAM_BASE+RAM_BYTES -> 8'h00, o_mem_error=1.
REQ-035 Host write 0x003=8'h03 -> o_start_draw one pulse next cycle; read 0x003 -> 8'h02.
REQ-036 Read and write both high at 0x100 -> o_mem_valid=1, o_mem_error=1, FRONT unchanged, bus Z.
REQ-037 Read 0x104 dropped in WAIT -> no o_mem_valid; reset asserted in WAIT of another read -> outputs return to reset values next cycle, no o_mem_valid.
REQ-038 Same-edge host write 8'h11 and memory write 8'h22 to 0x20C -> reads back 8'h11, memory-side completion shows o_mem_error=1.
